// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Round-robin arbiter/sequencer sharing one uart_tx among N_REQ byte-stream
// requesters. One byte is accepted per valid/ready handshake, framed as
// {start=0, data, stop=1}, launched with a one-cycle tx_start pulse, and the
// channel is held until tx_done returns.
//
// Optional feature macro: UART_ARB_LOCK_EN
//   When defined, a grant stays locked to one requester until a byte flagged
//   with req_last completes. When undefined, req_last is ignored and the
//   arbitration re-runs round-robin after every byte.
//
// Ports:
//   clk          system clock
//   reset_n      asynchronous active-low reset
//   req_valid    per-requester byte available
//   req_data     requester i data at [i*DATA_BITS +: DATA_BITS]
//   req_last     final byte of a packet (lock mode only)
//   req_ready    one-hot registered ready; transfer on valid & ready
//   frame_data   registered frame to uart_tx
//   tx_start     registered one-cycle start pulse to uart_tx
//   tx_busy      uart_tx busy, sampled only while idle
//   tx_done      uart_tx one-cycle completion pulse
//   grant_id     current or most recently granted requester
//   grant_active high from GRANT through WAIT
module uart_tx_arbiter #(
  parameter int N_REQ      = 4,
  parameter int DATA_BITS  = 8,
  parameter int FRAME_BITS = 10
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [N_REQ-1:0]             req_valid,
  input  logic [N_REQ*DATA_BITS-1:0]   req_data,
  input  logic [N_REQ-1:0]             req_last,
  output logic [N_REQ-1:0]             req_ready,
  output logic [FRAME_BITS-1:0]        frame_data,
  output logic                         tx_start,
  input  logic                         tx_busy,
  input  logic                         tx_done,
  output logic [$clog2(N_REQ)-1:0]     grant_id,
  output logic                         grant_active
);

  localparam int          GW = $clog2(N_REQ);
  localparam int unsigned NR = N_REQ;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    SEND  = 2'd2,
    WAIT  = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [N_REQ-1:0]        req_ready_q, req_ready_d;
  logic [FRAME_BITS-1:0]   frame_data_q, frame_data_d;
  logic                    tx_start_q, tx_start_d;
  logic [GW-1:0]           grant_id_q, grant_id_d;
  logic                    grant_active_q, grant_active_d;
  logic [GW-1:0]           last_grant_q, last_grant_d;

  logic                    win_found;
  logic [GW-1:0]           win_idx;
  logic [GW-1:0]           cand;

  logic [DATA_BITS-1:0]    data_arr [N_REQ];

  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign data_arr[i] = req_data[i*DATA_BITS +: DATA_BITS];
  end

`ifdef UART_ARB_LOCK_EN
  logic lock_q, lock_d;
  logic last_q, last_d;
`else
  logic unused_req_last;
  assign unused_req_last = ^req_last;
`endif

  // Round-robin search starting one past the last completed grant.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned off = 1; off <= NR; off++) begin
      cand = GW'((32'(last_grant_q) + off) % NR);
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
`ifdef UART_ARB_LOCK_EN
    // While locked only the owning requester is eligible.
    if (lock_q) begin
      win_found = req_valid[grant_id_q];
      win_idx   = grant_id_q;
    end
`endif
  end

  always_comb begin
    state_d        = state_q;
    req_ready_d    = req_ready_q;
    frame_data_d   = frame_data_q;
    tx_start_d     = 1'b0;
    grant_id_d     = grant_id_q;
    grant_active_d = grant_active_q;
    last_grant_d   = last_grant_q;
`ifdef UART_ARB_LOCK_EN
    lock_d         = lock_q;
    last_d         = last_q;
`endif

    case (state_q)
      IDLE: begin
        if (win_found && !tx_busy) begin
          grant_id_d           = win_idx;
          req_ready_d          = '0;
          req_ready_d[win_idx] = 1'b1;
          grant_active_d       = 1'b1;
          state_d              = GRANT;
        end
      end

      GRANT: begin
        req_ready_d = '0;
        if (req_valid[grant_id_q]) begin
          frame_data_d = {1'b0, data_arr[grant_id_q], 1'b1};
          tx_start_d   = 1'b1;
          state_d      = SEND;
`ifdef UART_ARB_LOCK_EN
          lock_d       = 1'b1;
          last_d       = req_last[grant_id_q];
`endif
        end else begin
          // Requester withdrew during GRANT: drop it, priority unchanged.
          grant_active_d = 1'b0;
          state_d        = IDLE;
        end
      end

      SEND, WAIT: begin
        if (tx_done) begin
          grant_active_d = 1'b0;
          state_d        = IDLE;
`ifdef UART_ARB_LOCK_EN
          if (last_q) begin
            lock_d       = 1'b0;
            last_grant_d = grant_id_q;
          end
`else
          last_grant_d   = grant_id_q;
`endif
        end else begin
          state_d = WAIT;
        end
      end

      default: begin
        state_d        = IDLE;
        req_ready_d    = '0;
        grant_active_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      req_ready_q    <= '0;
      frame_data_q   <= '1;
      tx_start_q     <= 1'b0;
      grant_id_q     <= '0;
      grant_active_q <= 1'b0;
      last_grant_q   <= GW'(N_REQ - 1);
`ifdef UART_ARB_LOCK_EN
      lock_q         <= 1'b0;
      last_q         <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      req_ready_q    <= req_ready_d;
      frame_data_q   <= frame_data_d;
      tx_start_q     <= tx_start_d;
      grant_id_q     <= grant_id_d;
      grant_active_q <= grant_active_d;
      last_grant_q   <= last_grant_d;
`ifdef UART_ARB_LOCK_EN
      lock_q         <= lock_d;
      last_q         <= last_d;
`endif
    end
  end

  assign req_ready    = req_ready_q;
  assign frame_data   = frame_data_q;
  assign tx_start     = tx_start_q;
  assign grant_id     = grant_id_q;
  assign grant_active = grant_active_q;

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter and sequencer that shares a single `uart_tx` transmitter among `N_REQ` byte-stream requesters. It accepts one byte per valid/ready handshake, builds the 10-bit frame `{start=0, data, stop=1}`, pulses `tx_start`, and holds the channel until `tx_done` returns. It sits directly in front of `uart_tx`, driving its `frame_data`/`tx_start` inputs and observing `tx_busy`/`tx_done`.

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `DATA_BITS`, 8: payload bits per frame.
- `FRAME_BITS`, 10: must equal `DATA_BITS + 2`. Matches `uart_tx` `FRAME_BITS`.
- `clk` in 1: system clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `req_valid` in N_REQ: per-requester byte available.
- `req_data` in N_REQ*DATA_BITS: requester i data at bits `[i*DATA_BITS +: DATA_BITS]`.
- `req_last` in N_REQ: final byte of a packet. Used only with `UART_ARB_LOCK_EN`.
- `req_ready` out N_REQ: one-hot, registered. The byte transfers on the edge where `req_valid[i] & req_ready[i]`.
- `frame_data` out FRAME_BITS: registered; goes to `uart_tx.frame_data`.
- `tx_start` out 1: registered one-cycle pulse; goes to `uart_tx.tx_start`.
- `tx_busy` in 1: from `uart_tx`.
- `tx_done` in 1: from `uart_tx`, one-cycle completion pulse.
- `grant_id` out $clog2(N_REQ): index of the current or last granted requester.
- `grant_active` out 1: high from GRANT through WAIT.

## Operation
- **FSM states:** IDLE, GRANT, SEND, WAIT.
- **IDLE:**
  - Condition: any `req_valid` high and `tx_busy`=0.
  - Winner: first requester with `req_valid` high, searching from `(last_grant+1) mod N_REQ` upward with wrap-around.
  - Action: register `grant_id`, set `req_ready[g]`=1, go to GRANT.
  - If `tx_busy`=1, stay in IDLE.
- **GRANT** (exactly 1 cycle):
  - `req_ready[g]`=1. The requester must hold `req_valid`/`req_data` stable until it sees `req_ready`.
  - On exit, capture `frame_data <= {1'b0, req_data[g], 1'b1}`, set `tx_start`=1, clear `req_ready`, go to SEND.
  - If `req_valid[g]` has dropped during GRANT (protocol violation): no capture, no `tx_start`, return to IDLE, `last_grant` unchanged.
- **SEND** (1 cycle): `tx_start`=1. Go to WAIT and clear `tx_start`.
- **WAIT:** hold `frame_data`. On `tx_done`=1, set `last_grant <= g` and go to IDLE.
  - A `tx_done` seen in SEND is also accepted and goes directly to IDLE.
- `tx_done` arriving in IDLE or GRANT is ignored.
- Non-granted requesters never see `req_ready`. Their `req_valid` may stay high indefinitely.
- At most one byte is outstanding. There is no internal buffering beyond `frame_data`.

## Timing
- **Reset values:**
  - `req_ready`=0, `tx_start`=0, `frame_data`=all ones (idle-high line pattern).
  - `grant_id`=0, `grant_active`=0, state=IDLE.
  - `last_grant`=N_REQ-1, so requester 0 has first priority.
- **Latency:** `req_valid` sampled high in IDLE at edge k, then `req_ready` is high in cycle k+1 and `tx_start` is high in cycle k+2 with `frame_data` valid.
  - `frame_data` is stable from cycle k+2 until the next GRANT exit.
- **Back-to-back:** from `tx_done` at edge d, the next grant takes `req_ready` high at d+2 at the earliest (IDLE at d+1, then GRANT).
- **Reset mid-operation:** all outputs return immediately to reset values and any pending byte is dropped. The requester re-presents the byte.
- `tx_busy` is only sampled in IDLE.

## Configuration
- **`UART_ARB_LOCK_EN` defined:**
  - A grant locks to requester g until a byte with `req_last[g]`=1 completes. `req_last` is captured in GRANT.
  - While locked, IDLE considers only requester g and waits indefinitely for its `req_valid`.
  - `last_grant` and the lock are released on completion of the last byte.
  - Adds a `lock` register, reset 0.
- **Undefined:** `req_last` is ignored, and arbitration re-runs round-robin after every byte.

## Test plan
- **Single byte:** after reset, `req_valid[0]`=1, `req_data[0]`=8'hAA → `req_ready`=4'b0001 for 1 cycle, `tx_start` pulse, `frame_data`=10'b0_10101010_1, `grant_id`=0. Then `tx_done` returns FSM to IDLE.
- **Round-robin:** all four `req_valid` high with data 8'h10..8'h13 → frames are sent in order 0,1,2,3,0, and each waits for the `tx_done` of the previous frame.
- **Busy hold-off:** `tx_busy`=1 in IDLE with `req_valid[2]`=1 → no `req_ready`. `tx_busy` falls, then `req_ready`=4'b0100 one cycle later.
- **Reset mid-WAIT:** assert `reset_n`=0 in WAIT → `tx_start`=0, `frame_data`=10'h3FF, `grant_active`=0. After release, requester 0 is granted first.
- **Lock (`UART_ARB_LOCK_EN`):** requester 1 sends 3 bytes with `req_last`=0,0,1 while requester 0 is valid → all 3 bytes go to requester 1, then requester 2, 3 or 0 is next per round-robin. Without the macro, 0 and 1 alternate.
- **Protocol violation:** `req_valid[3]` drops during GRANT → no `tx_start`, FSM returns to IDLE, next winner uses an unchanged `last_grant`.
